// File: rtl/kt8_pkg.sv
// Shared widths and word/address types for the KT8 8-bit CPU datapath.
package kt8_pkg;

  localparam int KT8_DATA_W = 8;
  localparam int KT8_ADDR_W = 4;

  typedef logic [KT8_DATA_W-1:0] kt8_word_t;
  typedef logic [KT8_ADDR_W-1:0] kt8_addr_t;

endpackage

// File: rtl/kt8_ram.sv
// KT8 single-port RAM: synchronous write, combinational read, optional clear on reset.
module kt8_ram
  import kt8_pkg::*;
#(
  parameter int DATA_W       = KT8_DATA_W,
  parameter int ADDR_W       = KT8_ADDR_W,
  parameter bit CLEAR_ON_RST = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] address_i,
  input  logic [DATA_W-1:0] in_i,
  input  logic              we_i,
  output logic [DATA_W-1:0] out_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Kept under the plain name mem so simulations can preload it hierarchically.
  logic [DATA_W-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      if (CLEAR_ON_RST) begin
        for (int i = 0; i < DEPTH; i++) begin
          mem[i] <= '0;
        end
      end
    end else if (we_i) begin
      mem[address_i] <= in_i;
    end
  end

  assign out_o = mem[address_i];

endmodule

// File: tb/tb_kt8_ram.sv
// Self-checking bench for kt8_ram: one instance per CLEAR_ON_RST setting, shared stimulus.
module tb_kt8_ram;

  logic       clk = 1'b0;
  logic       clkRun = 1'b0;
  logic       rstDrv = 1'b0;
  logic [3:0] addrDrv = '0;
  logic [7:0] inDrv = '0;
  logic       weDrv = 1'b0;
  logic [7:0] outKeep;
  logic [7:0] outClr;

  int vectors = 0;
  int miscompares = 0;

  // Reference contents per instance, plus which locations hold a defined value.
  logic [7:0] refKeep [16];
  logic [7:0] refClr  [16];
  bit         knownKeep [16];
  bit         knownClr  [16];

  kt8_ram #(.CLEAR_ON_RST(1'b0)) dut (
    .clk_i(clk), .rst_i(rstDrv), .address_i(addrDrv),
    .in_i(inDrv), .we_i(weDrv), .out_o(outKeep)
  );

  kt8_ram #(.CLEAR_ON_RST(1'b1)) dutClr (
    .clk_i(clk), .rst_i(rstDrv), .address_i(addrDrv),
    .in_i(inDrv), .we_i(weDrv), .out_o(outClr)
  );

  // Gated clock so combinational reads can be exercised with no edges at all.
  always begin
    #5;
    if (clkRun) clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: addr %0d observed %02h expected %02h", tag, addrDrv, obs, exp);
    end
  endtask

  task automatic checkBoth(input string tag);
    if (knownKeep[addrDrv]) checkOutput({tag, "_keep"}, outKeep, refKeep[addrDrv]);
    if (knownClr[addrDrv])  checkOutput({tag, "_clr"},  outClr,  refClr[addrDrv]);
  endtask

  task automatic applyStimulus(input logic [3:0] a, input logic [7:0] d,
                               input logic we, input logic rst);
    addrDrv = a;
    inDrv   = d;
    weDrv   = we;
    rstDrv  = rst;
  endtask

  task automatic modelEdge();
    if (rstDrv) begin
      for (int i = 0; i < 16; i++) begin
        refClr[i]   = 8'h00;
        knownClr[i] = 1'b1;
      end
    end else if (weDrv) begin
      refKeep[addrDrv]   = inDrv;
      knownKeep[addrDrv] = 1'b1;
      refClr[addrDrv]    = inDrv;
      knownClr[addrDrv]  = 1'b1;
    end
  endtask

  task automatic edgeCycle(input string tag);
    @(posedge clk);
    modelEdge();
    #1;
    checkBoth(tag);
    @(negedge clk);
  endtask

  task automatic stopClock();
    clkRun = 1'b0;
    #12;
  endtask

  task automatic startClock();
    clkRun = 1'b1;
  endtask

  task automatic sweepReads(input string tag);
    for (int a = 0; a < 16; a++) begin
      addrDrv = 4'(a);
      #1;
      checkBoth(tag);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      knownKeep[i] = 1'b0;
      knownClr[i]  = 1'b0;
      refKeep[i]   = 8'h00;
      refClr[i]    = 8'h00;
    end

    dut.mem[1]    = 8'h55;
    dutClr.mem[1] = 8'h55;
    dut.mem[2]    = 8'hC3;
    dutClr.mem[2] = 8'hC3;
    refKeep[1] = 8'h55; refClr[1] = 8'h55; knownKeep[1] = 1'b1; knownClr[1] = 1'b1;
    refKeep[2] = 8'hC3; refClr[2] = 8'hC3; knownKeep[2] = 1'b1; knownClr[2] = 1'b1;

    applyStimulus(4'd1, 8'h00, 1'b0, 1'b0);
    #1;
    checkBoth("preload1");
    addrDrv = 4'd2;
    #1;
    checkBoth("preload2");

    // Write with we raised before the edge; the old value must hold until the edge.
    applyStimulus(4'd1, 8'h0A, 1'b0, 1'b0);
    #1;
    weDrv = 1'b1;
    #1;
    checkBoth("pre_write");
    startClock();
    edgeCycle("write");
    applyStimulus(4'd1, 8'hFF, 1'b0, 1'b0);
    edgeCycle("we_off");

    applyStimulus(4'd2, 8'h33, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) edgeCycle("no_write");

    for (int n = 0; n < 16; n++) begin
      applyStimulus(4'(n), 8'(8'h10 + n), 1'b1, 1'b0);
      edgeCycle("fill");
    end
    weDrv = 1'b0;
    stopClock();
    sweepReads("fill_read");
    addrDrv = 4'd15;
    #1;
    checkOutput("top_addr", outKeep, 8'h1F);

    startClock();
    applyStimulus(4'd3, 8'h77, 1'b1, 1'b1);
    edgeCycle("rst_edge");
    applyStimulus(4'd3, 8'h77, 1'b0, 1'b0);
    stopClock();
    sweepReads("rst_read");
    addrDrv = 4'd3;
    #1;
    checkOutput("rst_keep3", outKeep, 8'h13);
    checkOutput("rst_clr3", outClr, 8'h00);

    startClock();
    for (int k = 0; k < 200; k++) begin
      applyStimulus(4'($urandom_range(0, 15)), 8'($urandom), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 15) == 0));
      #1;
      checkBoth("rnd_pre");
      edgeCycle("rnd_post");
    end
    applyStimulus(4'd0, 8'h00, 1'b0, 1'b0);
    stopClock();
    sweepReads("async_sweep");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
